// File: rtl/mvu_agu_pkg.sv
// Shared definitions for the nested input/weight address generator:
// run-state encoding, side indices and the flattened-bus field helper.
package mvu_agu_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } agu_state_t;

    localparam int NSIDES = 2;
    localparam int SIDE_I = 0;
    localparam int SIDE_W = 1;

    // Bit offset of field k in a bus made of equal w-bit fields.
    function automatic int fld_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/zigzag_seq.sv
// Zig-zag walk over (offw, offd) bit-plane pairs: anti-diagonals in order,
// offw ascending within each diagonal.
module zigzag_seq #(
    parameter int BPREC = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             step,
    input  logic             restart,
    input  logic [BPREC-1:0] pw,
    input  logic [BPREC-1:0] pd,
    output logic [BPREC-1:0] offw,
    output logic [BPREC-1:0] offd,
    output logic             sh,
    output logic             wrap
);

    logic [BPREC-1:0] offw_q, offw_d;
    logic [BPREC-1:0] offd_q, offd_d;
    logic [BPREC-1:0] pwm1, pdm1;
    logic [BPREC:0]   sn, nw, nd;

    assign pwm1 = pw - BPREC'(1);
    assign pdm1 = pd - BPREC'(1);

    // A diagonal ends when offw hits its ceiling or offd reaches zero.
    assign sh   = (offw_q == pwm1) || (offd_q == '0);
    assign wrap = (offw_q == pwm1) && (offd_q == pdm1);

    always_comb begin
        offw_d = offw_q;
        offd_d = offd_q;
        sn     = {1'b0, offw_q} + {1'b0, offd_q} + (BPREC+1)'(1);
        nw     = '0;
        nd     = '0;
        if (sn >= {1'b0, pd}) begin
            nw = sn - {1'b0, pd} + (BPREC+1)'(1);
        end
        nd = sn - nw;
        if (restart) begin
            offw_d = '0;
            offd_d = '0;
        end else if (step) begin
            if (wrap) begin
                offw_d = '0;
                offd_d = '0;
            end else if (!sh) begin
                offw_d = offw_q + BPREC'(1);
                offd_d = offd_q - BPREC'(1);
            end else begin
                offw_d = BPREC'(nw);
                offd_d = BPREC'(nd);
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            offw_q <= '0;
            offd_q <= '0;
        end else begin
            offw_q <= offw_d;
            offd_q <= offd_d;
        end
    end

    assign offw = offw_q;
    assign offd = offd_q;

endmodule

// File: rtl/nested_iwagu.sv
// Paired data/weight bank address generator: zig-zag bit-plane walk inside
// NLOOPS+1 nested word loops, with start/done handshake, repeat and abort.
module nested_iwagu
    import mvu_agu_pkg::*;
#(
    parameter int BPREC    = 6,
    parameter int BWBANKA  = 9,
    parameter int BDBANKA  = 15,
    parameter int BWLENGTH = 8,
    parameter int NLOOPS   = 4
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         en,
    input  logic                         repeat_mode,
    input  logic [BPREC-1:0]             iprecision,
    input  logic [BPREC-1:0]             wprecision,
    input  logic [(NLOOPS+1)*BWLENGTH-1:0] ilength,
    input  logic [(NLOOPS+1)*BWLENGTH-1:0] wlength,
    input  logic [NLOOPS*BDBANKA-1:0]    ijump,
    input  logic [NLOOPS*BWBANKA-1:0]    wjump,
    input  logic [BDBANKA-1:0]           ibaseaddr,
    input  logic [BWBANKA-1:0]           wbaseaddr,
    output logic                         busy,
    output logic                         valid,
    output logic [BDBANKA-1:0]           iaddr_out,
    output logic [BWBANKA-1:0]           waddr_out,
    output logic                         imsb,
    output logic                         wmsb,
    output logic                         sh_out,
    output logic [NLOOPS:0]              won_j,
    output logic [NLOOPS:0]              ion_j,
    output logic                         done
);

    localparam int AMAX = (BDBANKA > BWBANKA) ? BDBANKA : BWBANKA;
    localparam int LW   = (NLOOPS+1)*BWLENGTH;

    agu_state_t state_q, state_d;
    logic       done_q, done_d;
    logic       load, run, zz_step, word_adv;

    logic [BPREC-1:0]          ipr_q, wpr_q;
    logic [LW-1:0]             ilen_q, wlen_q;
    logic [NLOOPS*BDBANKA-1:0] ijmp_q;
    logic [NLOOPS*BWBANKA-1:0] wjmp_q;
    logic [BDBANKA-1:0]        ibase_q;
    logic [BWBANKA-1:0]        wbase_q;

    logic [BPREC-1:0] offw, offd;
    logic             zz_sh, zz_wrap;

    logic [NSIDES-1:0]                fin_s;
    logic [NSIDES-1:0][AMAX-1:0]      acc_s;
    logic [NSIDES-1:0][NLOOPS:0]      onj_s;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (en && zz_wrap && fin_s[SIDE_W] && !repeat_mode) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Zero precisions are clamped to 1 so the zig-zag always has a pair.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ipr_q   <= '0;
            wpr_q   <= '0;
            ilen_q  <= '0;
            wlen_q  <= '0;
            ijmp_q  <= '0;
            wjmp_q  <= '0;
            ibase_q <= '0;
            wbase_q <= '0;
        end else if (load) begin
            ipr_q   <= (iprecision == '0) ? BPREC'(1) : iprecision;
            wpr_q   <= (wprecision == '0) ? BPREC'(1) : wprecision;
            ilen_q  <= ilength;
            wlen_q  <= wlength;
            ijmp_q  <= ijump;
            wjmp_q  <= wjump;
            ibase_q <= ibaseaddr;
            wbase_q <= wbaseaddr;
        end
    end

    assign run      = (state_q == S_RUN);
    assign zz_step  = run && en && !abort;
    assign word_adv = zz_step && zz_wrap;

    zigzag_seq #(.BPREC(BPREC)) u_zz (
        .clk     (clk),
        .clr     (clr),
        .step    (zz_step),
        .restart (load),
        .pw      (wpr_q),
        .pd      (ipr_q),
        .offw    (offw),
        .offd    (offd),
        .sh      (zz_sh),
        .wrap    (zz_wrap)
    );

    for (genvar g = 0; g < NSIDES; g++) begin : g_side
        logic [BWLENGTH-1:0]         cnt_q [NLOOPS+1];
        logic [BWLENGTH-1:0]         cnt_d [NLOOPS+1];
        logic [AMAX-1:0]             acc_q, acc_d;
        logic [NLOOPS:0]             onj_q, onj_d;
        logic [LW-1:0]               len;
        logic [NLOOPS:0][AMAX-1:0]   stepv;
        logic                        fin, found;

        assign len      = (g == SIDE_I) ? ilen_q : wlen_q;
        assign stepv[0] = (g == SIDE_I) ? AMAX'(ipr_q) : AMAX'(wpr_q);

        // Jumps are zero-extended; only the low address bits are ever used,
        // so modular wrap makes negative jumps come out right.
        for (genvar k = 1; k <= NLOOPS; k++) begin : g_jmp
            if (g == SIDE_I) begin : g_i
                assign stepv[k] = AMAX'(ijmp_q[fld_lsb(k-1, BDBANKA) +: BDBANKA]);
            end else begin : g_w
                assign stepv[k] = AMAX'(wjmp_q[fld_lsb(k-1, BWBANKA) +: BWBANKA]);
            end
        end

        always_comb begin
            fin = 1'b1;
            for (int k = 0; k <= NLOOPS; k++) begin
                if (cnt_q[k] < len[fld_lsb(k, BWLENGTH) +: BWLENGTH]) begin
                    fin = 1'b0;
                end
            end
        end

        always_comb begin
            cnt_d = cnt_q;
            acc_d = acc_q;
            onj_d = onj_q;
            found = 1'b0;
            if (load || (word_adv && fin_s[SIDE_W]) || (word_adv && fin)) begin
                for (int k = 0; k <= NLOOPS; k++) begin
                    cnt_d[k] = '0;
                end
                acc_d = '0;
                onj_d = '0;
            end else if (word_adv) begin
                onj_d = '0;
                for (int k = 0; k <= NLOOPS; k++) begin
                    if (!found) begin
                        if (cnt_q[k] < len[fld_lsb(k, BWLENGTH) +: BWLENGTH]) begin
                            found    = 1'b1;
                            cnt_d[k] = cnt_q[k] + BWLENGTH'(1);
                            onj_d[k] = 1'b1;
                            acc_d    = acc_q + stepv[k];
                        end else begin
                            cnt_d[k] = '0;
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                for (int k = 0; k <= NLOOPS; k++) begin
                    cnt_q[k] <= '0;
                end
                acc_q <= '0;
                onj_q <= '0;
            end else begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
                onj_q <= onj_d;
            end
        end

        assign fin_s[g] = fin;
        assign acc_s[g] = acc_q;
        assign onj_s[g] = onj_q;
    end

    assign busy      = run;
    assign valid     = run;
    assign done      = done_q;
    assign iaddr_out = run ? BDBANKA'(AMAX'(ibase_q) + acc_s[SIDE_I] + AMAX'(offd)) : '0;
    assign waddr_out = run ? BWBANKA'(AMAX'(wbase_q) + acc_s[SIDE_W] + AMAX'(offw)) : '0;
    assign imsb      = run && (offd == '0);
    assign wmsb      = run && (offw == '0);
    assign sh_out    = run && zz_sh;
    assign ion_j     = run ? onj_s[SIDE_I] : '0;
    assign won_j     = run ? onj_s[SIDE_W] : '0;

endmodule

// File: tb/tb_nested_iwagu.sv
// Directed bench for nested_iwagu: zig-zag order, nested jumps, stalls,
// repeat/abort, address wrap, async clear and zero-precision clamping.
module tb_nested_iwagu;

    logic        clk, clr, start, abort, en, repeat_mode;
    logic [5:0]  iprecision, wprecision;
    logic [39:0] ilength, wlength;
    logic [59:0] ijump;
    logic [35:0] wjump;
    logic [14:0] ibaseaddr;
    logic [8:0]  wbaseaddr;
    logic        busy, valid, imsb, wmsb, sh_out, done;
    logic [14:0] iaddr_out;
    logic [8:0]  waddr_out;
    logic [4:0]  won_j, ion_j;

    int n_tests = 0;
    int n_fail  = 0;

    nested_iwagu dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort), .en(en),
        .repeat_mode(repeat_mode), .iprecision(iprecision), .wprecision(wprecision),
        .ilength(ilength), .wlength(wlength), .ijump(ijump), .wjump(wjump),
        .ibaseaddr(ibaseaddr), .wbaseaddr(wbaseaddr), .busy(busy), .valid(valid),
        .iaddr_out(iaddr_out), .waddr_out(waddr_out), .imsb(imsb), .wmsb(wmsb),
        .sh_out(sh_out), .won_j(won_j), .ion_j(ion_j), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Test 1/3 expectations: four zig-zag pairs for pw=pd=2.
    int t1_i [4] = '{100, 101, 100, 101};
    int t1_w [4] = '{10, 10, 11, 11};
    int t1_sh[4] = '{1, 0, 1, 1};
    int t1_im[4] = '{1, 0, 1, 0};
    int t1_wm[4] = '{1, 1, 0, 0};
    // Test 2/4 expectations: six words over a two-level nest.
    int t2_i [6] = '{0, 1, 2, 7, 8, 9};
    int t2_w [6] = '{0, 1, 2, 5, 6, 7};
    int t2_j [6] = '{0, 1, 1, 2, 1, 1};

    task automatic cfg_t1();
        iprecision = 6'd2; wprecision = 6'd2;
        ilength = '0; wlength = '0; ijump = '0; wjump = '0;
        ibaseaddr = 15'd100; wbaseaddr = 9'd10;
    endtask

    task automatic cfg_t2();
        iprecision = 6'd1; wprecision = 6'd1;
        ilength = '0; wlength = '0;
        ilength[7:0] = 8'd2; ilength[15:8] = 8'd1;
        wlength[7:0] = 8'd2; wlength[15:8] = 8'd1;
        ijump = '0; wjump = '0;
        ijump[14:0] = 15'd5; wjump[8:0] = 9'd3;
        ibaseaddr = '0; wbaseaddr = '0;
    endtask

    initial begin
        clk = 0; clr = 1; start = 0; abort = 0; en = 1; repeat_mode = 0;
        cfg_t1();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_iaddr", iaddr_out, 0);
        chk("rst_waddr", waddr_out, 0);
        chk("rst_done", done, 0);
        clr = 0;
        tick();

        // Test 1: basic zig-zag
        cfg_t1();
        start_run();
        for (int p = 0; p < 4; p++) begin
            chk("t1_valid", valid, 1);
            chk("t1_iaddr", iaddr_out, t1_i[p]);
            chk("t1_waddr", waddr_out, t1_w[p]);
            chk("t1_sh", sh_out, t1_sh[p]);
            chk("t1_imsb", imsb, t1_im[p]);
            chk("t1_wmsb", wmsb, t1_wm[p]);
            chk("t1_done_lo", done, 0);
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_valid_end", valid, 0);
        tick();
        chk("t1_done_pulse", done, 0);

        // Test 2: nested word loops
        cfg_t2();
        start_run();
        for (int w = 0; w < 6; w++) begin
            chk("t2_valid", valid, 1);
            chk("t2_iaddr", iaddr_out, t2_i[w]);
            chk("t2_waddr", waddr_out, t2_w[w]);
            chk("t2_ionj", ion_j, t2_j[w]);
            chk("t2_wonj", won_j, t2_j[w]);
            tick();
        end
        chk("t2_done", done, 1);
        chk("t2_busy_end", busy, 0);
        tick();

        // Test 3: stall after pair 2
        cfg_t1();
        start_run();
        for (int p = 0; p < 4; p++) begin
            chk("t3_iaddr", iaddr_out, t1_i[p]);
            chk("t3_waddr", waddr_out, t1_w[p]);
            if (p == 1) begin
                en = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    chk("t3_hold_i", iaddr_out, t1_i[1]);
                    chk("t3_hold_w", waddr_out, t1_w[1]);
                    chk("t3_hold_valid", valid, 1);
                    chk("t3_hold_done", done, 0);
                end
                en = 1'b1;
            end
            tick();
        end
        chk("t3_done", done, 1);
        tick();

        // Test 4: repeat mode then abort
        cfg_t2();
        repeat_mode = 1'b1;
        start_run();
        for (int w = 0; w < 8; w++) begin
            chk("t4_iaddr", iaddr_out, t2_i[w % 6]);
            chk("t4_ionj", ion_j, t2_j[w % 6]);
            chk("t4_done", done, 0);
            chk("t4_valid", valid, 1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat_mode = 1'b0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_valid", valid, 0);
        chk("t4_abort_done", done, 0);
        tick();
        chk("t4_abort_done2", done, 0);

        // Test 5: modular wrap on a large jump
        cfg_t2();
        ilength = '0; wlength = '0;
        ilength[15:8] = 8'd1; wlength[15:8] = 8'd1;
        ijump[14:0] = 15'h7FFF; wjump[8:0] = 9'd2;
        start_run();
        chk("t5_iaddr0", iaddr_out, 0);
        tick();
        chk("t5_iaddr1", iaddr_out, 15'h7FFF);
        chk("t5_waddr1", waddr_out, 2);
        chk("t5_ionj1", ion_j, 2);
        tick();
        chk("t5_done", done, 1);
        tick();

        // Test 6: zero weight precision, start ignored in RUN, async clear
        iprecision = 6'd1; wprecision = 6'd0;
        ilength = '0; wlength = '0; wlength[7:0] = 8'd2;
        ijump = '0; wjump = '0; ibaseaddr = '0; wbaseaddr = '0;
        start_run();
        chk("t6_waddr0", waddr_out, 0);
        chk("t6_sh0", sh_out, 1);
        start = 1'b1; ibaseaddr = 15'd500;
        tick();
        start = 1'b0;
        chk("t6_waddr1", waddr_out, 1);
        chk("t6_iaddr_ign", iaddr_out, 0);
        chk("t6_busy", busy, 1);
        #2 clr = 1'b1;
        #1;
        chk("t6_clr_busy", busy, 0);
        chk("t6_clr_valid", valid, 0);
        chk("t6_clr_waddr", waddr_out, 0);
        #1 clr = 1'b0;
        tick();
        chk("t6_idle", busy, 0);
        chk("t6_nodone", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
